// File: rtl/gpu_sram_pkg.sv
// Shared defaults and request address-split constants for the GPU local-store
// SRAM bank controller.
package gpu_sram_pkg;
  localparam int DW_DEF       = 8;
  localparam int AW_DEF       = 11;
  localparam int NB_DEF       = 2;
  localparam int RQ_DEPTH_DEF = 2;

  // Request address layout: bank select in the low bits, row directly above it.
  localparam int BANK_LSB = 0;

  function automatic int row_lsb(input int nb);
    return $clog2(nb);
  endfunction
endpackage

// File: rtl/sram_bank.sv
// One bank of the local store: an sram_gpu macro with active-high select/write
// converted to the macro's active-low strobes and its test pins tied off.
module sram_bank #(
  parameter int DW = 8,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          ce,
  input  logic          we,
  input  logic [AW-1:0] row,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic cen;
  logic wen;

  assign cen = ~ce;
  assign wen = ~we;

  sram_gpu #(
    .DW(DW),
    .AW(AW)
  ) u_macro (
    .clk  (clk),
    .cen  (cen),
    .wen  (wen),
    .a    (row),
    .d    (wdata),
    .ema  (3'b000),
    .retn (1'b1),
    .q    (rdata)
  );
endmodule

// File: rtl/sram_gpu.sv
// Behavioural model of the single-port sram_gpu macro: active-low CEN/WEN,
// registered read data that holds between reads.
module sram_gpu #(
  parameter int DW = 8,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          cen,
  input  logic          wen,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] d,
  input  logic [2:0]    ema,
  input  logic          retn,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];
  logic          unused_ema;

  // Margin control only trims timing on silicon; it has no logical effect here.
  assign unused_ema = ^ema;

  always_ff @(posedge clk) begin
    if (!cen && retn) begin
      if (!wen) begin
        mem[a] <= d;
      end else begin
        q <= mem[a];
      end
    end
  end
endmodule

// File: rtl/sram_bank_ctrl.sv
// NB-bank SRAM controller: credit-gated request accept, one-deep in-flight read
// tag, and an in-order response FIFO that captures macro data one edge later.
module sram_bank_ctrl
  import gpu_sram_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int NB       = NB_DEF,
  parameter int RQ_DEPTH = RQ_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_wen,
  input  logic                        req_wide,
  input  logic [AW+$clog2(NB)-1:0]    req_addr,
  input  logic [NB*DW-1:0]            req_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [NB*DW-1:0]            rsp_rdata
);
  localparam int BW      = $clog2(NB);
  localparam int ROW_LSB = row_lsb(NB);
  localparam int RW      = NB * DW;
  localparam int PW      = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam int CNT_W   = $clog2(RQ_DEPTH + 1);
  localparam int CW      = $clog2(RQ_DEPTH + 2) + 1;

  logic              accept;
  logic              push;
  logic              pop;
  logic [BW-1:0]     req_bank;
  logic [AW-1:0]     req_row;
  logic [NB-1:0]     bank_ce;
  logic [DW-1:0]     bank_q [NB];
  logic [RW-1:0]     wide_q;
  logic [RW-1:0]     push_data;
  logic              inflight_valid_reg;
  logic              inflight_wide_reg;
  logic [BW-1:0]     inflight_bank_reg;
  logic [RW-1:0]     fifo_mem [RQ_DEPTH];
  logic [PW-1:0]     wr_ptr_reg;
  logic [PW-1:0]     rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CW-1:0]     used;
  logic [CW-1:0]     avail;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(RQ_DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign req_bank = req_addr[BANK_LSB +: BW];
  assign req_row  = req_addr[ROW_LSB +: AW];

  // A pop this cycle frees a slot for a request accepted on the same edge.
  assign pop       = (count_reg != '0) && rsp_ready;
  assign used      = CW'(count_reg) + CW'(inflight_valid_reg);
  assign avail     = CW'(RQ_DEPTH) + CW'(pop);
  assign req_ready = rst_n && (used < avail);
  assign accept    = req_valid && req_ready;
  assign push      = inflight_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_bank
      assign bank_ce[gi] = accept && (req_wide || (req_bank == BW'(gi)));

      sram_bank #(
        .DW(DW),
        .AW(AW)
      ) u_bank (
        .clk   (clk),
        .ce    (bank_ce[gi]),
        .we    (req_wen),
        .row   (req_row),
        .wdata (req_wide ? req_wdata[gi*DW +: DW] : req_wdata[DW-1:0]),
        .rdata (bank_q[gi])
      );

      assign wide_q[gi*DW +: DW] = bank_q[gi];
    end
  endgenerate

  assign push_data = inflight_wide_reg ? wide_q : RW'(bank_q[inflight_bank_reg]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_valid_reg <= 1'b0;
      inflight_wide_reg  <= 1'b0;
      inflight_bank_reg  <= '0;
      wr_ptr_reg         <= '0;
      rd_ptr_reg         <= '0;
      count_reg          <= '0;
    end else begin
      inflight_valid_reg <= accept && !req_wen;
      if (accept) begin
        inflight_wide_reg <= req_wide;
        inflight_bank_reg <= req_bank;
      end
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= push_data;
    end
  end

  assign rsp_valid = (count_reg != '0);
  assign rsp_rdata = rsp_valid ? fifo_mem[rd_ptr_reg] : '0;
endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed bench for sram_bank_ctrl: reset, narrow/wide access, back-pressure,
// streaming and reset-during-read, each against hand-computed values.
module tb_sram_bank_ctrl;
  localparam int DW = 8;
  localparam int AW = 11;
  localparam int NB = 2;
  localparam int RQ_DEPTH = 2;
  localparam int AD = AW + 1;
  localparam int RW = NB * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_wen;
  logic          req_wide;
  logic [AD-1:0] req_addr;
  logic [RW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [RW-1:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  logic [AD-1:0] addr_t [8];
  logic          wide_t [8];
  logic [RW-1:0] exp_t  [8];

  always #5 clk = ~clk;

  sram_bank_ctrl #(
    .DW(DW), .AW(AW), .NB(NB), .RQ_DEPTH(RQ_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_wide(req_wide), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata)
  );

  always @(posedge clk) begin
    if (req_valid && req_ready)
      $display("%0t req %s %s addr=0x%03h wdata=0x%04h", $time, req_wen ? "wr" : "rd",
               req_wide ? "wide" : "narrow", req_addr, req_wdata);
    if (rsp_valid && rsp_ready)
      $display("%0t rsp rdata=0x%04h", $time, rsp_rdata);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit v, input bit wen, input bit wide,
                           input logic [AD-1:0] a, input logic [RW-1:0] d);
    req_valid = v;
    req_wen   = wen;
    req_wide  = wide;
    req_addr  = a;
    req_wdata = d;
  endtask

  // Issues one read with an empty queue and rsp_ready=1; returns what was observed.
  task automatic read_once(input logic [AD-1:0] a, input bit wide, output bit rdy,
                           output bit early_v, output bit late_v, output logic [RW-1:0] data);
    drive_req(1'b1, 1'b0, wide, a, '0);
    @(negedge clk);
    rdy = req_ready;
    tick();
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    early_v = rsp_valid;
    tick();
    @(negedge clk);
    late_v = rsp_valid;
    data = rsp_rdata;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    drive_req(1'b1, 1'b1, 1'b1, '0, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      checks++; if (rsp_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0000", rsp_rdata); end
      checks++; if (dut.bank_ce !== 2'b00) begin errors++; $display("FAIL reset_bank_ce: got %b want 00", dut.bank_ce); end
      tick();
    end
    rst_n = 1'b1;
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    tick();
  endtask

  task automatic test_narrow();
    bit rdy, ev, lv;
    logic [RW-1:0] d;
    drive_req(1'b1, 1'b1, 1'b0, 12'h004, 16'h0077);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL narrow_wr_ready: got %b want 1", req_ready); end
    checks++; if (dut.bank_ce !== 2'b01) begin errors++; $display("FAIL narrow_wr0_bank_ce: got %b want 01", dut.bank_ce); end
    tick();
    drive_req(1'b1, 1'b1, 1'b0, 12'h005, 16'h00A5);
    @(negedge clk);
    checks++; if (dut.bank_ce !== 2'b10) begin errors++; $display("FAIL narrow_wr1_bank_ce: got %b want 10", dut.bank_ce); end
    tick();
    read_once(12'h005, 1'b0, rdy, ev, lv, d);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL narrow_rd_ready: got %b want 1", rdy); end
    checks++; if (ev !== 1'b0) begin errors++; $display("FAIL narrow_rd_early_valid: got %b want 0", ev); end
    checks++; if (lv !== 1'b1) begin errors++; $display("FAIL narrow_rd_valid: got %b want 1", lv); end
    checks++; if (d !== 16'h00A5) begin errors++; $display("FAIL narrow_rd_data: got %h want 00a5", d); end
    read_once(12'h004, 1'b0, rdy, ev, lv, d);
    checks++; if (d !== 16'h0077) begin errors++; $display("FAIL narrow_bank0_untouched: got %h want 0077", d); end
  endtask

  task automatic test_wide();
    bit rdy, ev, lv;
    logic [RW-1:0] d;
    drive_req(1'b1, 1'b1, 1'b1, 12'h006, 16'h1234);
    @(negedge clk);
    checks++; if (dut.bank_ce !== 2'b11) begin errors++; $display("FAIL wide_wr_bank_ce: got %b want 11", dut.bank_ce); end
    tick();
    read_once(12'h006, 1'b0, rdy, ev, lv, d);
    checks++; if (d !== 16'h0034) begin errors++; $display("FAIL wide_rd_bank0: got %h want 0034", d); end
    read_once(12'h007, 1'b0, rdy, ev, lv, d);
    checks++; if (d !== 16'h0012) begin errors++; $display("FAIL wide_rd_bank1: got %h want 0012", d); end
    read_once(12'h006, 1'b1, rdy, ev, lv, d);
    checks++; if (lv !== 1'b1) begin errors++; $display("FAIL wide_rd_valid: got %b want 1", lv); end
    checks++; if (d !== 16'h1234) begin errors++; $display("FAIL wide_rd_data: got %h want 1234", d); end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b0;
    drive_req(1'b1, 1'b0, 1'b0, 12'h006, '0);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_a: got %b want 1", req_ready); end
    tick();
    drive_req(1'b1, 1'b0, 1'b0, 12'h007, '0);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_b: got %b want 1", req_ready); end
    tick();
    drive_req(1'b1, 1'b0, 1'b0, 12'h005, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready: got %b want 0", req_ready); end
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold_valid: got %b want 1", rsp_valid); end
      checks++; if (rsp_rdata !== 16'h0034) begin errors++; $display("FAIL b2b_hold_data: got %h want 0034", rsp_rdata); end
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_pop_ready: got %b want 1", req_ready); end
    checks++; if (rsp_rdata !== 16'h0034) begin errors++; $display("FAIL b2b_rsp0: got %h want 0034", rsp_rdata); end
    tick();
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if (rsp_rdata !== 16'h0012) begin errors++; $display("FAIL b2b_rsp1: got %h want 0012", rsp_rdata); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_rsp2_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_rdata !== 16'h00A5) begin errors++; $display("FAIL b2b_rsp2: got %h want 00a5", rsp_rdata); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", rsp_valid); end
    tick();
  endtask

  task automatic test_stream();
    bit rdy, ev, lv;
    logic [RW-1:0] d;
    drive_req(1'b1, 1'b1, 1'b0, 12'h010, 16'h005A);
    tick();
    read_once(12'h010, 1'b0, rdy, ev, lv, d);
    checks++; if (d !== 16'h005A) begin errors++; $display("FAIL raw_rd_data: got %h want 005a", d); end
    addr_t = '{12'h005, 12'h006, 12'h007, 12'h010, 12'h004, 12'h006, 12'h004, 12'h007};
    wide_t = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_t  = '{16'h00A5, 16'h0034, 16'h0012, 16'h005A, 16'h0077, 16'h1234, 16'hA577, 16'h0012};
    for (int k = 0; k < 10; k++) begin
      if (k < 8) drive_req(1'b1, 1'b0, wide_t[k], addr_t[k], '0);
      else       drive_req(1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      if (k < 8) begin
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b want 1", k, req_ready); end
      end
      if (k == 1) begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stream_first_bubble: got %b want 0", rsp_valid); end
      end
      if (k >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp_t[k-2]) begin
          errors++; $display("FAIL stream_rsp[%0d]: got valid=%b data=%h want valid=1 data=%h", k - 2, rsp_valid, rsp_rdata, exp_t[k-2]);
        end
      end
      tick();
    end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL stream_drained: got %b want 0", rsp_valid); end
    tick();
  endtask

  task automatic test_reset_flush();
    bit rdy, ev, lv;
    logic [RW-1:0] d;
    drive_req(1'b1, 1'b0, 1'b0, 12'h005, '0);
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b want 1", req_ready); end
    tick();
    rst_n = 1'b0;
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL flush_inflight_valid: got %b want 0", rsp_valid); end
    tick();
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_rst_ready: got %b want 0", req_ready); end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 16'h0000) begin errors++; $display("FAIL flush_discarded: got valid=%b data=%h want valid=0 data=0000", rsp_valid, rsp_rdata); end
      tick();
    end
    read_once(12'h005, 1'b0, rdy, ev, lv, d);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL flush_after_ready: got %b want 1", rdy); end
    checks++; if (lv !== 1'b1 || d !== 16'h00A5) begin errors++; $display("FAIL flush_mem_kept: got valid=%b data=%h want valid=1 data=00a5", lv, d); end
  endtask

  initial begin
    drive_req(1'b0, 1'b0, 1'b0, '0, '0);
    test_reset();
    test_narrow();
    test_wide();
    test_back_to_back();
    test_stream();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
